uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_parity_gen.sv | 24 ++
 rtl/uart_tx_cfg.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

   localparam int BREAK_BITS = 13;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PAR_NONE     = 2'b00,
      PAR_EVEN     = 2'b01,
      PAR_ODD      = 2'b10,
      PAR_NONE_ALT = 2'b11
   } parity_e;

   typedef enum logic [1:0] {
      STOP_1     = 2'b00,
      STOP_1P5   = 2'b01,
      STOP_2     = 2'b10,
      STOP_2_ALT = 2'b11
   } stop_e;

endpackage

// File: rtl/uart_parity_gen.sv
// Parity over the low i_nbits bits of i_data; odd mode inverts the XOR.
module uart_parity_gen
   import uart_pkg::*;
#(
   parameter int W = 9
) (
   input  logic [W-1:0] i_data,
   input  logic [3:0]   i_nbits,
   input  logic [1:0]   i_mode,
   output logic         o_par
);

   logic w_x;

   always_comb begin
      w_x = 1'b0;
      for (int i = 0; i < W; i++)
         if (i < int'(i_nbits))
            w_x = w_x ^ i_data[i];
   end

   assign o_par = (i_mode == PAR_ODD) ? ~w_x : w_x;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data length, parity and stop config,
// plus line-break generation.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9,
   parameter int OVRSAMPLING   = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     s_tick,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [MAX_DATA_BITS-1:0] din,
   input  logic [3:0]               cfg_data_bits,
   input  logic [1:0]               cfg_parity,
   input  logic [1:0]               cfg_stop,
   input  logic                     break_req,
   output logic                     tx_done,
   output logic                     busy,
   output logic                     tx
);

   localparam int CW = $clog2(2*OVRSAMPLING);
   localparam logic [CW-1:0] TOP_BIT = CW'(OVRSAMPLING-1);
   localparam logic [CW-1:0] TOP_1P5 = CW'(3*OVRSAMPLING/2-1);
   localparam logic [CW-1:0] TOP_2   = CW'(2*OVRSAMPLING-1);
   localparam logic [3:0]    NB_MIN  = 4'd5;
   localparam logic [3:0]    NB_MAX  = 4'(MAX_DATA_BITS);
   localparam logic [3:0]    BRK_N   = 4'(BREAK_BITS);

   state_e                   r_state;
   logic [CW-1:0]            r_cnt;
   logic [3:0]               r_idx;
   logic [3:0]               r_nbits;
   logic [MAX_DATA_BITS-1:0] r_shift;
   logic                     r_par_en;
   logic                     r_par;
   logic [1:0]               r_stop;
   logic                     r_from_brk;
   logic                     r_tx;
   logic                     r_done;

   logic [3:0]               w_nbits;
   logic                     w_par;
   logic                     w_par_en;
   logic [CW-1:0]            w_stop_top;
   logic                     w_bit_end;
   logic                     w_brk_exit;

   always_comb begin
      w_nbits = cfg_data_bits;
      if (cfg_data_bits < NB_MIN)
         w_nbits = NB_MIN;
      else if (cfg_data_bits > NB_MAX)
         w_nbits = NB_MAX;
   end

   uart_parity_gen #(
      .W (MAX_DATA_BITS)
   ) u_par (
      .i_data  (din),
      .i_nbits (w_nbits),
      .i_mode  (cfg_parity),
      .o_par   (w_par)
   );

   assign w_par_en = (cfg_parity == PAR_EVEN) ||
                     (cfg_parity == PAR_ODD);

   always_comb begin
      case (r_stop)
         STOP_1:   w_stop_top = TOP_BIT;
         STOP_1P5: w_stop_top = TOP_1P5;
         default:  w_stop_top = TOP_2;
      endcase
   end

   assign w_bit_end = s_tick && (r_cnt == TOP_BIT);

   // Leave break on the very tick that completes the minimum length.
   assign w_brk_exit = !break_req &&
                       ((r_idx == BRK_N) ||
                        (w_bit_end && (r_idx == BRK_N - 4'd1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_nbits    <= '0;
         r_shift    <= '0;
         r_par_en   <= 1'b0;
         r_par      <= 1'b0;
         r_stop     <= '0;
         r_from_brk <= 1'b0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (break_req) begin
                  r_state    <= ST_BREAK;
                  r_tx       <= 1'b0;
                  r_idx      <= '0;
                  r_from_brk <= 1'b1;
               end else if (tx_valid) begin
                  r_state    <= ST_START;
                  r_tx       <= 1'b0;
                  r_shift    <= din;
                  r_nbits    <= w_nbits;
                  r_par_en   <= w_par_en;
                  r_par      <= w_par;
                  r_stop     <= cfg_stop;
                  r_from_brk <= 1'b0;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= ST_DATA;
                  r_tx    <= r_shift[0];
               end else if (s_tick) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_idx == r_nbits - 4'd1) begin
                     r_state <= r_par_en ? ST_PARITY : ST_STOP;
                     r_tx    <= r_par_en ? r_par : 1'b1;
                  end else begin
                     r_idx   <= r_idx + 4'd1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end else if (s_tick) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
               end else if (s_tick) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (s_tick) begin
                  if (r_cnt == w_stop_top) begin
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                     r_done  <= !r_from_brk;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_BREAK: begin
               if (w_brk_exit) begin
                  r_cnt   <= '0;
                  r_state <= ST_STOP;
                  r_stop  <= cfg_stop;
                  r_tx    <= 1'b1;
               end else if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_idx != BRK_N)
                     r_idx <= r_idx + 4'd1;
               end else if (s_tick) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign tx_ready = (r_state == ST_IDLE) && !break_req;
   assign busy     = (r_state != ST_IDLE);
   assign tx       = r_tx;
   assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: per-tick line levels of each frame vs a frame model.
module tb_uart_tx_cfg;

   localparam int MDB = 9;
   localparam int OS  = 16;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           s_tick = 1'b0;
   logic           tx_valid = 1'b0;
   logic           break_req = 1'b0;
   logic [MDB-1:0] din = '0;
   logic [3:0]     cfg_data_bits = 4'd8;
   logic [1:0]     cfg_parity = 2'd0;
   logic [1:0]     cfg_stop = 2'd0;
   logic           tx_ready;
   logic           tx_done;
   logic           busy;
   logic           tx;

   typedef struct {
      logic [255:0] vec;
      int           len;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;

   uart_tx_cfg #(
      .MAX_DATA_BITS (MDB),
      .OVRSAMPLING   (OS)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_tick        (s_tick),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .din           (din),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop      (cfg_stop),
      .break_req     (break_req),
      .tx_done       (tx_done),
      .busy          (busy),
      .tx            (tx)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1 s_tick = ($urandom_range(0, 1) == 1);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   // Frame as a list of bit levels, each held OS ticks, then stop ticks.
   function automatic exp_t model(input logic [MDB-1:0] d, input int bits,
                                  input int par, input int stp);
      exp_t e;
      logic lv[$];
      logic p;
      int   nb;
      int   ns;
      e.vec = '0;
      e.len = 0;
      nb = (bits < 5) ? 5 : ((bits > MDB) ? MDB : bits);
      lv.push_back(1'b0);
      p = 1'b0;
      for (int i = 0; i < nb; i++) begin
         lv.push_back(d[i]);
         p = p ^ d[i];
      end
      if (par == 1) lv.push_back(p);
      if (par == 2) lv.push_back(~p);
      foreach (lv[k])
         for (int t = 0; t < OS; t++) begin
            e.vec[e.len] = lv[k];
            e.len++;
         end
      ns = (stp == 0) ? OS : ((stp == 1) ? (3 * OS) / 2 : 2 * OS);
      for (int t = 0; t < ns; t++) begin
         e.vec[e.len] = 1'b1;
         e.len++;
      end
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: collect tx per tick while busy, compare on tx_done.
   initial begin
      logic [255:0] col_vec;
      int           col_len;
      exp_t         e;
      col_vec = '0;
      col_len = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            col_vec = '0;
            col_len = 0;
         end else if (tx_done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame: got unexpected tx_done, expected none");
            end else begin
               e = exp_q.pop_front();
               if (e.len != col_len || e.vec != col_vec) begin
                  errors++;
                  $display("FAIL frame: got len=%0d bits=%h, expected len=%0d bits=%h",
                           col_len, col_vec, e.len, e.vec);
               end
            end
            col_vec = '0;
            col_len = 0;
         end else if (!busy) begin
            col_vec = '0;
            col_len = 0;
         end else if (s_tick && col_len < 256) begin
            col_vec[col_len] = tx;
            col_len++;
         end
      end
   end

   task automatic send(input logic [MDB-1:0] d, input int bits,
                       input int par, input int stp);
      int n;
      n = 0;
      @(negedge clk);
      while (!tx_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      din           = d;
      cfg_data_bits = 4'(bits);
      cfg_parity    = 2'(par);
      cfg_stop      = 2'(stp);
      tx_valid      = 1'b1;
      exp_q.push_back(model(d, bits, par, stp));
      @(posedge clk);
      #1;
      tx_valid      = 1'b0;
      din           = MDB'($urandom);
      cfg_data_bits = 4'($urandom);
      cfg_parity    = 2'($urandom);
      cfg_stop      = 2'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 5000);
      if (busy) check("idle_timeout", 1, 0);
   endtask

   initial begin
      int n;
      int g;
      int bad;
      int st;
      int d0;
      int dn;
      int idle;

      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", tx_done, 0);
      reset_n = 1'b1;
      #1 check("rst_ready", tx_ready, 1);

      send(9'h055, 8, 0, 0);
      send(9'h041, 7, 1, 2);
      send(9'h1FF, 9, 2, 1);
      send(9'h0AB, 3, 1, 0);
      send(9'h155, 15, 2, 3);
      for (int i = 0; i < 6; i++)
         send(MDB'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      wait_idle();

      // Long break, released after 300 ticks, stop length 1.5 bits.
      d0 = done_cnt;
      cfg_stop  = 2'b01;
      break_req = 1'b1;
      #1 check("brk_ready_now", tx_ready, 0);
      @(posedge clk);
      n = 0; g = 0; bad = 0;
      while (n < 300 && g < 20000) begin
         @(negedge clk);
         g++;
         if (tx != 1'b0 || tx_ready) bad++;
         if (s_tick) n++;
      end
      break_req = 1'b0;
      check("brk_low_bad", bad, 0);
      check("brk_ticks", n, 300);
      @(posedge clk);
      st = 0; g = 0; bad = 0;
      while (g < 5000) begin
         @(negedge clk);
         g++;
         if (!busy) break;
         if (tx != 1'b1) bad++;
         if (s_tick) st++;
      end
      check("brk_stop_high", bad, 0);
      check("brk_stop_ticks", st, 24);
      check("brk_no_done", done_cnt, d0);

      // Short break request still yields the minimum break length.
      @(negedge clk);
      cfg_stop  = 2'b00;
      break_req = 1'b1;
      @(posedge clk);
      n = 0; g = 0;
      while (g < 20000) begin
         @(negedge clk);
         g++;
         if (tx == 1'b1) break;
         if (s_tick) n++;
         if (n == 20) break_req = 1'b0;
      end
      break_req = 1'b0;
      check("brk_min_ticks", n, 13 * OS);
      wait_idle();
      check("brk2_no_done", done_cnt, d0);

      // Reset during data bit 3.
      send(9'h0F3, 8, 0, 0);
      n = 0; g = 0;
      while (n < 72 && g < 5000) begin
         @(negedge clk);
         g++;
         if (s_tick) n++;
      end
      reset_n = 1'b0;
      #1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", tx_done, 0);
      void'(exp_q.pop_back());
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("mid_rst_ready", tx_ready, 1);
      send(9'h1C6, 8, 1, 0);
      wait_idle();

      // tx_valid held across three frames.
      @(negedge clk);
      din           = 9'h0A5;
      cfg_data_bits = 4'd8;
      cfg_parity    = 2'd1;
      cfg_stop      = 2'd0;
      for (int i = 0; i < 3; i++)
         exp_q.push_back(model(9'h0A5, 8, 1, 0));
      tx_valid = 1'b1;
      dn = 0; idle = 0; g = 0;
      while (dn < 3 && g < 20000) begin
         @(negedge clk);
         g++;
         if (tx_done) dn++;
         if (!busy && dn >= 1 && dn < 3) idle++;
      end
      tx_valid = 1'b0;
      check("b2b_done", dn, 3);
      check("b2b_idle", idle, 2);

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
